// File: rtl/fft4_sequencer.sv
// rtl/fft4_sequencer.sv - 4-point radix-2 FFT sequencer driving an external butterfly.
// Optional input 1/N scaling is enabled by defining FFT4_INPUT_SCALE_EN.
module fft4_sequencer #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_last,
  output logic             busy,
  output logic [WIDTH-1:0] bf_a,
  output logic [WIDTH-1:0] bf_b,
  output logic [WIDTH-1:0] bf_w,
  input  logic [WIDTH-1:0] bf_out0,
  input  logic [WIDTH-1:0] bf_out1
);

  localparam int HALF = WIDTH / 2;
  // W0 = +1 (largest positive Q value), W1 = -j
  localparam logic [WIDTH-1:0] TW0 = {1'b0, {(HALF-1){1'b1}}, {HALF{1'b0}}};
  localparam logic [WIDTH-1:0] TW1 = {{HALF{1'b0}}, 1'b1, {(HALF-1){1'b0}}};

  typedef enum logic [1:0] {
    S_LOAD,
    S_STAGE1,
    S_STAGE2,
    S_UNLOAD
  } state_t;

  state_t           state_q, state_d;
  logic [1:0]       cnt_q, cnt_d;
  logic [WIDTH-1:0] mem_q [0:3];
  logic [WIDTH-1:0] mem_d [0:3];
  logic [WIDTH-1:0] sample;
  logic [1:0]       idx_a, idx_b;

`ifdef FFT4_INPUT_SCALE_EN
  logic signed [HALF-1:0] in_re, in_im;
  assign in_re  = $signed(in_data[WIDTH-1:HALF]);
  assign in_im  = $signed(in_data[HALF-1:0]);
  assign sample = {in_re >>> 2, in_im >>> 2};
`else
  assign sample = in_data;
`endif

  // Stage 1 pairs adjacent words (0,1)/(2,3); stage 2 pairs (0,2)/(1,3).
  always_comb begin
    idx_a = 2'd0;
    idx_b = 2'd0;
    if (state_q == S_STAGE1) begin
      idx_a = {cnt_q[0], 1'b0};
      idx_b = {cnt_q[0], 1'b1};
    end else begin
      idx_a = {1'b0, cnt_q[0]};
      idx_b = {1'b1, cnt_q[0]};
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    mem_d     = mem_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    out_last  = 1'b0;
    out_data  = '0;
    busy      = 1'b0;
    bf_a      = '0;
    bf_b      = '0;
    bf_w      = '0;
    case (state_q)
      S_LOAD: begin
        in_ready = 1'b1;
        if (in_valid) begin
          mem_d[{cnt_q[0], cnt_q[1]}] = sample;
          cnt_d = cnt_q + 2'd1;
          if (cnt_q == 2'd3) state_d = S_STAGE1;
        end
      end
      S_STAGE1, S_STAGE2: begin
        busy         = 1'b1;
        bf_a         = mem_q[idx_a];
        bf_b         = mem_q[idx_b];
        bf_w         = (state_q == S_STAGE2 && cnt_q[0]) ? TW1 : TW0;
        mem_d[idx_a] = bf_out0;
        mem_d[idx_b] = bf_out1;
        if (cnt_q[0]) begin
          cnt_d   = 2'd0;
          state_d = (state_q == S_STAGE1) ? S_STAGE2 : S_UNLOAD;
        end else begin
          cnt_d = cnt_q + 2'd1;
        end
      end
      S_UNLOAD: begin
        out_valid = 1'b1;
        out_data  = mem_q[cnt_q];
        out_last  = (cnt_q == 2'd3);
        if (out_ready) begin
          cnt_d = cnt_q + 2'd1;
          if (cnt_q == 2'd3) state_d = S_LOAD;
        end
      end
      default: state_d = S_LOAD;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_LOAD;
      cnt_q   <= 2'd0;
      for (int i = 0; i < 4; i++) mem_q[i] <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      for (int i = 0; i < 4; i++) mem_q[i] <= mem_d[i];
    end
  end

endmodule

// File: doc/fft4_sequencer.md
Name: fft4_sequencer

Overview:
- Control and storage stage wrapped around one external combinational butterfly (WIDTH=32, packed {real, imag} Q1.15).
- Accepts 4 complex time-domain samples over a valid/ready stream and stores them in bit-reversed order.
- Drives the butterfly for 2 radix-2 stages (4 ops), writes results back, then streams out X0..X3 in natural order.
- Sits directly upstream of, and consumes, the butterfly; forms the 4-point FFT datapath.

Parameters:
- WIDTH, 32, packed complex word width; HALF=WIDTH/2 per component, {real[WIDTH-1:HALF], imag[HALF-1:0]}, signed Q1.15 at default.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- in_valid  in  1  input sample valid.
- in_ready  out  1  block can accept a sample.
- in_data  in  WIDTH  packed complex input sample.
- out_valid  out  1  output bin valid.
- out_ready  in  1  downstream accepts the bin.
- out_data  out  WIDTH  packed complex FFT bin.
- out_last  out  1  high with X3 beat.
- busy  out  1  high in STAGE1/STAGE2.
- bf_a  out  WIDTH  butterfly A operand.
- bf_b  out  WIDTH  butterfly B operand.
- bf_w  out  WIDTH  butterfly twiddle.
- bf_out0  in  WIDTH  butterfly A+B*W.
- bf_out1  in  WIDTH  butterfly A-B*W.

Behaviour:
- Reset (rst_n=0 at a clk edge): state=LOAD, counters=0, memory m0..m3=0, in_ready=1, out_valid=0, out_last=0, busy=0, out_data=0, bf_a/bf_b/bf_w=0. Reset mid-frame discards the partial frame with no output.
- LOAD: in_ready=1. Sample k (k=0..3, on an in_valid&in_ready edge) is written to m[bitrev(k)]: x0->m0, x1->m2, x2->m1, x3->m3. After the 4th handshake -> STAGE1.
- STAGE1: 2 cycles, one op per cycle, twiddle W0={16'h7FFF,16'h0000}.
  - op0: A=m0, B=m1; out0->m0, out1->m1.
  - op1: A=m2, B=m3; out0->m2, out1->m3.
  - Then -> STAGE2.
- STAGE2: 2 cycles.
  - op0: A=m0, B=m2, W=W0; out0->m0, out1->m2.
  - op1: A=m1, B=m3, W=W1={16'h0000,16'h8000} (-j); out0->m1, out1->m3.
  - Then -> UNLOAD.
- Butterfly results are captured at the end of each op cycle; bf_* outputs are driven combinationally from state/op counter and are 0 outside STAGE1/STAGE2.
- UNLOAD: out_valid=1 and out_data=m[j] for j=0..3 in natural order. j advances only on out_valid&out_ready; out_data is stable while stalled. out_last=1 when j=3. After the 4th handshake -> LOAD, with in_ready=1 the next cycle.
- in_ready=0 outside LOAD; in_valid in other states is ignored (no capture).
- Frame latency: last input handshake -> first out_valid = 4 cycles.
- No internal saturation: memory holds the butterfly result bits verbatim and wraps per two's complement.
- Throughput: one frame per 4 + 4 + 4 cycles minimum.

Optional Feature:
- Macro FFT4_INPUT_SCALE_EN.
- Defined: at LOAD, real and imag components are each arithmetic-shifted right by 2 before storage (1/N scaling, no output overflow for any in-range input).
- Undefined: samples are stored unmodified.

Test Plan (real butterfly instance attached, WIDTH=32, macro off unless stated):
- Impulse: in = 0x4000_0000, 0, 0, 0 with out_ready=1 -> four beats 0x4000_0000, out_last on beat 4; first out_valid 4 cycles after the last input handshake.
- DC: all four inputs 0x1000_0000 -> outputs 0x3FFD_0000, 0x0001_FFFF, 0x0001_0000, 0x0001_0001.
- Backpressure: impulse frame with out_ready toggled 1,0,0,1,... -> out_data held stable during stalls; exactly 4 beats; in_ready=0 until the final beat completes.
- Reset mid-operation: rst_n=0 for 1 cycle during STAGE2 -> next cycle in_ready=1, out_valid=0, busy=0; a following impulse frame gives correct results.
- Ignored input: in_valid held high with 0x7FFF_7FFF throughout STAGE1/STAGE2/UNLOAD -> no capture; the frame's outputs match the pure impulse result.
- FFT4_INPUT_SCALE_EN defined, impulse 0x4000_0000 -> four beats 0x1000_0000.
